sprite_palette_banked: RTL and testbench
========================================

SPRITE_PALETTE_BANKED -- requirements
Module: sprite_palette_banked

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 4, giving the pixel index width (2^INDEX_W entries per bank).
REQ-002 The block SHALL have parameter NUM_BANKS, default 4, giving the number of palette banks (power of two, at least 1).
REQ-003 The block SHALL have parameter FLASH_FRAMES, default 8, giving the flash duration in frames (1..255).
REQ-004 The block SHALL have parameter FLASH_COLOR, default 12'hFFF, giving the {R,G,B} colour forced during flash.
REQ-005 The block SHALL have parameter TRANSP_EN, default 1, which enables index 0 as the transparent index.
REQ-006 The block SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port px_valid, input, 1 bit: lookup request this cycle.
REQ-009 The block SHALL have port px_index, input, INDEX_W bits: pixel colour index.
REQ-010 The block SHALL have port px_bank, input, clog2(NUM_BANKS) bits (minimum 1 bit): bank select for the lookup.
REQ-011 The block SHALL have port wr_en, input, 1 bit: palette entry write strobe.
REQ-012 The block SHALL have ports wr_bank, input, bank width, and wr_index, input, INDEX_W bits: the write address.
REQ-013 The block SHALL have port wr_data, input, 12 bits: {R[3:0],G[3:0],B[3:0]}.
REQ-014 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse per video frame.
REQ-015 The block SHALL have port flash_start, input, 1 bit: one-cycle pulse that starts or restarts the flash.
REQ-016 The block SHALL have ports red, green, blue, output, 4 bits each: the looked-up colour.
REQ-017 The block SHALL have port out_valid, output, 1 bit: red/green/blue/transparent are valid.
REQ-018 The block SHALL have port transparent, output, 1 bit: the pixel is to be skipped by the compositor.
REQ-019 The block SHALL have port flashing, output, 1 bit: high while in the FLASH state.

Function
REQ-020 Storage SHALL be NUM_BANKS x 2^INDEX_W entries of 12 bits, held in registers.
REQ-021 Lookup SHALL be a two-stage pipeline: stage 1 registers px_valid/px_index/px_bank; stage 2 reads the array and registers the outputs; out_valid equals px_valid delayed exactly 2 cycles.
REQ-022 The pipeline SHALL accept one lookup per cycle with no stalls; back-to-back lookups SHALL produce back-to-back outputs.
REQ-023 When out_valid is 0, red/green/blue/transparent SHALL hold their previous values.
REQ-024 A write SHALL update one entry on the edge where wr_en=1.
REQ-025 A write at edge N SHALL be visible to lookups sampled at edge N or later, and SHALL NOT be visible to lookups sampled at edge N-1 or earlier.
REQ-026 Out-of-range bank values (when NUM_BANKS is not a power of two) SHALL be ignored on write and SHALL return 12'h000 on lookup.
REQ-027 If TRANSP_EN=1 and the registered index is 0, the output SHALL be transparent=1 with red=green=blue=0, regardless of entry contents or flash state.
REQ-028 The flash FSM SHALL have two states, IDLE and FLASH, with an 8-bit frame counter.
REQ-029 IDLE -> FLASH on flash_start; the counter SHALL load FLASH_FRAMES.
REQ-030 In FLASH, each frame_start pulse SHALL decrement the counter; the decrement that reaches 0 SHALL return the FSM to IDLE on that same edge.
REQ-031 flash_start in FLASH SHALL reload FLASH_FRAMES; when flash_start and frame_start coincide, the reload SHALL win.
REQ-032 In FLASH, every non-transparent valid output SHALL carry FLASH_COLOR instead of the palette entry; flash state SHALL be sampled at stage 2.
REQ-033 flashing SHALL be 1 exactly while the FSM is in FLASH.

Reset
REQ-034 On Reset_n=0, asynchronously: pipeline valids=0; red/green/blue=0; out_valid=0; transparent=0; flashing=0; FSM=IDLE; counter=0.
REQ-035 On Reset_n=0, entry 0 of every bank SHALL be set to 12'hF0F and all other entries to 12'h000.
REQ-036 Reset asserted mid-lookup or mid-flash SHALL discard in-flight lookups; no out_valid SHALL follow the release of reset without a new px_valid.
REQ-037 Reset SHALL release synchronously to Clk.

Verification
REQ-038 Write bank 2, index 5 = 12'h9A3; lookup (2,5) -> 2 cycles later out_valid=1, {R,G,B}={9,A,3}, transparent=0.
REQ-039 Write (1,7)=12'h123 at edge N while a lookup of (1,7) is sampled at N-1 and another at N -> outputs 12'h000 then 12'h123, on consecutive cycles.
REQ-040 Lookup index 0 in any bank with TRANSP_EN=1, both idle and flashing -> transparent=1, RGB=0.
REQ-041 flash_start, then lookup (0,3)=12'h456 -> output 12'hFFF, flashing=1; after 8 frame_start pulses, flashing=0 and output 12'h456.
REQ-042 In FLASH with counter=1, flash_start coincident with frame_start -> the FSM stays in FLASH and the counter is 8.
REQ-043 Reset_n pulsed low mid-stream with 2 lookups in flight -> out_valid=0 and flashing=0 immediately; every entry reads back its reset value.

Source files
------------

// File: rtl/sprite_palette_banked.sv
// Sprite palette lookup with NUM_BANKS register-based banks of 2^INDEX_W
// 12-bit {R,G,B} entries, a two-stage lookup pipeline, an optional
// transparent index 0 and a frame-counted "flash" override colour.
//
// Reset_n asserts asynchronously everywhere; its release is re-timed to Clk
// through a two-flop synchroniser so that every state element leaves reset
// on the same clock edge.

module sprite_palette_banked #(
  parameter int         INDEX_W      = 4,
  parameter int         NUM_BANKS    = 4,
  parameter int         FLASH_FRAMES = 8,
  parameter logic [11:0] FLASH_COLOR = 12'hFFF,
  parameter bit         TRANSP_EN    = 1'b1,
  localparam int        BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               px_valid,
  input  logic [INDEX_W-1:0] px_index,
  input  logic [BANK_W-1:0]  px_bank,
  input  logic               wr_en,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [11:0]        wr_data,
  input  logic               frame_start,
  input  logic               flash_start,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               out_valid,
  output logic               transparent,
  output logic               flashing
);

  localparam int              ENTRIES      = 2 ** INDEX_W;
  localparam logic [11:0]     ENTRY0_RESET = 12'hF0F;
  localparam logic [7:0]      FLASH_LOAD   = 8'(FLASH_FRAMES);
  // One bit wider than a bank number so that NUM_BANKS itself is representable.
  localparam logic [BANK_W:0] BANK_LIMIT   = (BANK_W + 1)'(NUM_BANKS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  // Reset synchroniser
  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Palette storage
  logic [11:0] mem_r [NUM_BANKS][ENTRIES];

  // Lookup stage 1
  logic               s1_valid_r;
  logic [INDEX_W-1:0] s1_index_r;
  logic [BANK_W-1:0]  s1_bank_r;

  // Lookup stage 2 (output registers)
  logic [11:0] rgb_r;
  logic        out_valid_r;
  logic        transp_r;

  // Flash FSM
  flash_state_t state_r;
  flash_state_t state_next_s;
  logic [7:0]   cnt_r;
  logic [7:0]   cnt_next_s;
  logic         flashing_r;

  // Address qualification and stage-2 colour selection
  logic        wr_bank_ok_s;
  logic        rd_bank_ok_s;
  logic [11:0] entry_s;
  logic [11:0] color_s;
  logic        transp_s;

  // Async-assert / sync-release reset: internal reset drops two edges after Reset_n rises.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Bank numbers at or above NUM_BANKS only exist when NUM_BANKS is not a power of two.
  always_comb begin
    wr_bank_ok_s = 1'b0;
    rd_bank_ok_s = 1'b0;
    if ({1'b0, wr_bank} < BANK_LIMIT) begin
      wr_bank_ok_s = 1'b1;
    end else begin
      wr_bank_ok_s = 1'b0;
    end
    if ({1'b0, s1_bank_r} < BANK_LIMIT) begin
      rd_bank_ok_s = 1'b1;
    end else begin
      rd_bank_ok_s = 1'b0;
    end
  end

  // Palette array: reset pattern on reset, single-entry update on a qualified write.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem_r[b][e] <= (e == 0) ? ENTRY0_RESET : 12'h000;
        end
      end
    end else if (wr_en && wr_bank_ok_s) begin
      mem_r[wr_bank][wr_index] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Stage 1: capture the lookup request.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      s1_valid_r <= 1'b0;
      s1_index_r <= {INDEX_W{1'b0}};
      s1_bank_r  <= {BANK_W{1'b0}};
    end else begin
      s1_valid_r <= px_valid;
      s1_index_r <= px_index;
      s1_bank_r  <= px_bank;
    end
  end

  // Stage-2 read. The array is read before this edge's write lands, so a write
  // on edge N reaches a lookup captured at N but not one captured at N-1.
  always_comb begin
    entry_s = 12'h000;
    if (rd_bank_ok_s) begin
      entry_s = mem_r[s1_bank_r][s1_index_r];
    end else begin
      entry_s = 12'h000;
    end
  end

  // Stage-2 colour priority: transparent index, then flash override, then palette.
  always_comb begin
    color_s  = 12'h000;
    transp_s = 1'b0;
    if (TRANSP_EN && (s1_index_r == {INDEX_W{1'b0}})) begin
      transp_s = 1'b1;
      color_s  = 12'h000;
    end else if (state_r == FLASH) begin
      transp_s = 1'b0;
      color_s  = FLASH_COLOR;
    end else begin
      transp_s = 1'b0;
      color_s  = entry_s;
    end
  end

  // Stage 2: register outputs; colour and transparent hold while no lookup completes.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      out_valid_r <= 1'b0;
      rgb_r       <= 12'h000;
      transp_r    <= 1'b0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        rgb_r    <= color_s;
        transp_r <= transp_s;
      end else begin
        rgb_r    <= rgb_r;
        transp_r <= transp_r;
      end
    end
  end

  // Flash FSM next state: flash_start (re)loads the frame count and beats frame_start.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (flash_start) begin
          state_next_s = FLASH;
          cnt_next_s   = FLASH_LOAD;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = cnt_r;
        end
      end
      FLASH: begin
        if (flash_start) begin
          state_next_s = FLASH;
          cnt_next_s   = FLASH_LOAD;
        end else if (frame_start) begin
          if (cnt_r <= 8'd1) begin
            state_next_s = IDLE;
            cnt_next_s   = 8'd0;
          end else begin
            state_next_s = FLASH;
            cnt_next_s   = cnt_r - 8'd1;
          end
        end else begin
          state_next_s = FLASH;
          cnt_next_s   = cnt_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // Flash FSM state, frame counter and the registered flashing flag.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      flashing_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      flashing_r <= (state_next_s == FLASH);
    end
  end

  assign red         = rgb_r[11:8];
  assign green       = rgb_r[7:4];
  assign blue        = rgb_r[3:0];
  assign out_valid   = out_valid_r;
  assign transparent = transp_r;
  assign flashing    = flashing_r;

endmodule

// File: tb/tb_sprite_palette_banked.sv
// Directed bench for sprite_palette_banked. Two instances share every input:
// dut uses the defaults, dut3 has three banks (bank 3 out of range) and no
// transparent index so the reset pattern of entry 0 is observable.

module tb_sprite_palette_banked;

  logic        Clk;
  logic        Reset_n;
  logic        px_valid;
  logic [3:0]  px_index;
  logic [1:0]  px_bank;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_data;
  logic        frame_start;
  logic        flash_start;

  logic [3:0] red, green, blue;
  logic       out_valid, transparent, flashing;
  logic [3:0] red3, green3, blue3;
  logic       out_valid3, transparent3, flashing3;

  int checks;
  int errors;

  sprite_palette_banked dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .px_valid(px_valid), .px_index(px_index), .px_bank(px_bank),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
    .frame_start(frame_start), .flash_start(flash_start),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .transparent(transparent), .flashing(flashing)
  );

  sprite_palette_banked #(.NUM_BANKS(3), .TRANSP_EN(1'b0)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n),
    .px_valid(px_valid), .px_index(px_index), .px_bank(px_bank),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
    .frame_start(frame_start), .flash_start(flash_start),
    .red(red3), .green(green3), .blue(blue3),
    .out_valid(out_valid3), .transparent(transparent3), .flashing(flashing3)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] b, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [1:0] b, input logic [3:0] i);
    px_valid = 1'b1; px_bank = b; px_index = i;
    tick();
    px_valid = 1'b0;
    tick();
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic do_flash_start();
    flash_start = 1'b1;
    tick();
    flash_start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset_n = 1'b0;
    px_valid = 1'b0; px_index = 4'd0; px_bank = 2'd0;
    wr_en = 1'b0; wr_bank = 2'd0; wr_index = 4'd0; wr_data = 12'h000;
    frame_start = 1'b0; flash_start = 1'b0;

    // Reset state
    #2;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_rgb", {red, green, blue}, 12'h000);
    check_val("rst_transp", transparent, 0);
    check_val("rst_flashing", flashing, 0);
    #10 Reset_n = 1'b1;
    tick(); tick(); tick();

    // Basic write and lookup
    do_write(2'd2, 4'd5, 12'h9A3);
    do_lookup(2'd2, 4'd5);
    check_val("lk_valid", out_valid, 1);
    check_val("lk_rgb", {red, green, blue}, 12'h9A3);
    check_val("lk_transp", transparent, 0);
    check_val("lk3_rgb", {red3, green3, blue3}, 12'h9A3);
    tick();
    check_val("hold_valid", out_valid, 0);
    check_val("hold_rgb", {red, green, blue}, 12'h9A3);

    // Write/lookup ordering around the same edge
    px_valid = 1'b1; px_bank = 2'd1; px_index = 4'd7;
    tick();
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd7; wr_data = 12'h123;
    tick();
    wr_en = 1'b0; px_valid = 1'b0;
    check_val("raw_old_valid", out_valid, 1);
    check_val("raw_old_rgb", {red, green, blue}, 12'h000);
    tick();
    check_val("raw_new_valid", out_valid, 1);
    check_val("raw_new_rgb", {red, green, blue}, 12'h123);

    // Back-to-back lookups stream without gaps
    do_write(2'd0, 4'd3, 12'h456);
    px_valid = 1'b1; px_bank = 2'd2; px_index = 4'd5;
    tick();
    px_bank = 2'd1; px_index = 4'd7;
    tick();
    check_val("b2b_0", {out_valid, red, green, blue}, 13'h19A3);
    px_bank = 2'd0; px_index = 4'd3;
    tick();
    px_valid = 1'b0;
    check_val("b2b_1", {out_valid, red, green, blue}, 13'h1123);
    tick();
    check_val("b2b_2", {out_valid, red, green, blue}, 13'h1456);

    // Transparent index while idle; dut3 shows entry 0 reset pattern
    do_lookup(2'd2, 4'd0);
    check_val("tr_idle", {transparent, red, green, blue}, 13'h1000);
    check_val("tr3_idle", {transparent3, red3, green3, blue3}, 13'h0F0F);

    // Out-of-range bank on dut3: write ignored, lookup returns zero
    do_write(2'd3, 4'd2, 12'hABC);
    do_lookup(2'd3, 4'd2);
    check_val("oor_in_range", {red, green, blue}, 12'hABC);
    check_val("oor_valid3", out_valid3, 1);
    check_val("oor_rgb3", {red3, green3, blue3}, 12'h000);

    // Flash override and countdown
    do_flash_start();
    check_val("fl_on", flashing, 1);
    check_val("fl_on3", flashing3, 1);
    do_lookup(2'd0, 4'd3);
    check_val("fl_rgb", {red, green, blue}, 12'hFFF);
    check_val("fl_rgb3", {red3, green3, blue3}, 12'hFFF);
    do_lookup(2'd1, 4'd0);
    check_val("fl_tr", {transparent, red, green, blue}, 13'h1000);
    check_val("fl_tr3", {transparent3, red3, green3, blue3}, 13'h0FFF);
    for (int k = 0; k < 7; k++) do_frame();
    check_val("fl_7frames", flashing, 1);
    do_frame();
    check_val("fl_8frames", flashing, 0);
    do_lookup(2'd0, 4'd3);
    check_val("fl_after_rgb", {red, green, blue}, 12'h456);

    // Reload wins over a coincident final frame_start
    do_flash_start();
    for (int k = 0; k < 7; k++) do_frame();
    check_val("rl_cnt1", flashing, 1);
    flash_start = 1'b1; frame_start = 1'b1;
    tick();
    flash_start = 1'b0; frame_start = 1'b0;
    check_val("rl_stay", flashing, 1);
    for (int k = 0; k < 7; k++) do_frame();
    check_val("rl_7frames", flashing, 1);
    do_frame();
    check_val("rl_8frames", flashing, 0);

    // Reset mid-stream with lookups in flight and flash active
    do_flash_start();
    px_valid = 1'b1; px_bank = 2'd2; px_index = 4'd5;
    tick();
    px_bank = 2'd1; px_index = 4'd7;
    tick();
    px_valid = 1'b0;
    check_val("mid_pre_valid", out_valid, 1);
    check_val("mid_pre_flash", flashing, 1);
    Reset_n = 1'b0;
    #1;
    check_val("mid_valid", out_valid, 0);
    check_val("mid_flash", flashing, 0);
    check_val("mid_rgb", {red, green, blue}, 12'h000);
    #10 Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("post_rst_valid", {out_valid, out_valid3}, 2'b00);
    end

    // Every entry reads back its reset value
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin
        do_lookup(2'(b), 4'(i));
        check_val("rb_rgb", {red, green, blue}, 12'h000);
        check_val("rb_transp", transparent, (i == 0) ? 1 : 0);
        check_val("rb3_rgb", {red3, green3, blue3}, (i == 0 && b < 3) ? 12'hF0F : 12'h000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
